// File: rtl/axis_uart_tx_cfg_if.sv
// AXI-Stream word channel between a source and the UART transmitter.
interface axis_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_tx_cfg.sv
// AXIS-fed UART transmitter: sync FIFO plus a framer with per-frame baud divisor,
// parity and stop-bit settings captured at the start of every frame.
module axis_uart_tx_cfg #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  axis_if.slave                         s_axis,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  // FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level, level_nxt;
  logic              full_q;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  // Framer
  state_t            state;
  logic [DIV_W-1:0]  cnt, div_q;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_idx;
  logic              par_en, par_bit, stop2_q;
  logic              tick, last_stop;

  // tready depends only on the registered full flag, so a pop never reopens it in the same cycle
  assign s_axis.tready = !full_q;
  assign push          = s_axis.tvalid && !full_q;
  assign head          = mem[rd_ptr];
  assign fifo_level    = level;
  assign busy          = (state != IDLE) || (level != '0);

  assign tick      = (cnt == '0);
  assign last_stop = tick && (((state == STOP1) && !stop2_q) || (state == STOP2));
  assign pop       = (level != '0) && ((state == IDLE) || last_stop);

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_axis.tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level  <= level_nxt;
      full_q <= (level_nxt == FULL_LVL);
    end
  end

  // Each state holds for div_q+1 cycles: the counter reloads on entry and the
  // state advances on the cycle it reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      div_q   <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      stop2_q <= 1'b0;
    end else if (pop) begin
      // Frame start (from IDLE or straight out of the last stop bit): capture config.
      state   <= START;
      tx      <= 1'b0;
      cnt     <= baud_div;
      div_q   <= baud_div;
      shreg   <= head;
      bit_idx <= '0;
      par_en  <= parity_mode[0] ^ parity_mode[1];
      par_bit <= (^head) ^ (parity_mode == 2'b10);
      stop2_q <= stop2;
    end else if (state != IDLE) begin
      if (!tick) begin
        cnt <= cnt - DIV_W'(1);
      end else begin
        cnt <= div_q;
        case (state)
          START: begin
            state <= DATA;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end
          DATA: begin
            if (bit_idx == LAST_BIT) begin
              state <= par_en ? PARITY : STOP1;
              tx    <= par_en ? par_bit : 1'b1;
            end else begin
              bit_idx <= bit_idx + BW'(1);
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
          PARITY: begin
            state <= STOP1;
            tx    <= 1'b1;
          end
          STOP1: begin
            state <= stop2_q ? STOP2 : IDLE;
            tx    <= 1'b1;
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_uart_tx_cfg.sv
// Directed bench for axis_uart_tx_cfg: frame shape, parity, stop bits, FIFO fill, reset, config timing.
module tb_axis_uart_tx_cfg;
  logic        clk;
  logic        rst_n;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        tx;
  logic        busy;
  logic [4:0]  fifo_level;
  int          n_cmp;
  int          n_fail;

  axis_if #(.DATA_W(8)) bus ();

  axis_uart_tx_cfg #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(bus), .baud_div(baud_div),
    .parity_mode(parity_mode), .stop2(stop2), .tx(tx), .busy(busy), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One handshake: drive at negedge, accepted at the following rising edge.
  task automatic push(input logic [7:0] d);
    @(negedge clk);
    bus.tdata  = d;
    bus.tvalid = 1'b1;
    @(posedge clk);
    #1 bus.tvalid = 1'b0;
  endtask

  // Records tx at the first and last cycle of each bit period.
  task automatic capture(input int nbits, input int per,
                         output logic [31:0] first, output logic [31:0] last);
    first = '0;
    last  = '0;
    for (int c = 0; c < nbits * per; c++) begin
      @(negedge clk);
      if (c % per == 0)       first[c / per] = tx;
      if (c % per == per - 1) last[c / per]  = tx;
    end
  endtask

  task automatic test_reset;
    bus.tvalid = 1'b0; bus.tdata = '0;
    baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (tx !== 1'b1)       begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    n_cmp++; if (bus.tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready got %b want 1", bus.tready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_frame;
    logic [31:0] f, l, e;
    baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    e = {22'd0, 1'b1, 8'hA5, 1'b0};
    push(8'hA5);
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1)       begin n_fail++; $display("FAIL basic_latency_tx got %b want 1", tx); end
    n_cmp++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL basic_level got %0d want 1", fifo_level); end
    capture(10, 4, f, l);
    n_cmp++; if (f !== e) begin n_fail++; $display("FAIL basic_first got %b want %b", f, e); end
    n_cmp++; if (l !== e) begin n_fail++; $display("FAIL basic_last got %b want %b", l, e); end
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL basic_idle_tx got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_parity;
    logic [31:0] f, l, e;
    baud_div = 16'd3; stop2 = 1'b0;
    for (int m = 1; m <= 2; m++) begin
      parity_mode = 2'(m);
      e = (m == 1) ? {21'd0, 1'b1, 1'b1, 8'h07, 1'b0} : {21'd0, 1'b1, 1'b0, 8'h07, 1'b0};
      push(8'h07);
      @(negedge clk);
      capture(11, 4, f, l);
      n_cmp++; if (f !== e) begin n_fail++; $display("FAIL parity%0d_first got %b want %b", m, f, e); end
      n_cmp++; if (l !== e) begin n_fail++; $display("FAIL parity%0d_last got %b want %b", m, l, e); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL parity%0d_end_busy got %b want 0", m, busy); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] f, l, e;
    baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b1;
    e = {10'd0, 2'b11, 8'hFF, 1'b0, 2'b11, 8'h00, 1'b0};
    push(8'h00);
    push(8'hFF);
    capture(22, 4, f, l);
    n_cmp++; if (f !== e) begin n_fail++; $display("FAIL b2b_first got %b want %b", f, e); end
    n_cmp++; if (l !== e) begin n_fail++; $display("FAIL b2b_last got %b want %b", l, e); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy got %b want 0", busy); end
    stop2 = 1'b0;
  endtask

  task automatic test_div0;
    logic [31:0] f, l, e;
    baud_div = 16'd0; parity_mode = 2'b01; stop2 = 1'b1;
    e = {20'd0, 2'b11, 1'b0, 8'h96, 1'b0};
    push(8'h96);
    @(negedge clk);
    capture(12, 1, f, l);
    n_cmp++; if (f !== e) begin n_fail++; $display("FAIL div0_bits got %b want %b", f, e); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div0_end_busy got %b want 0", busy); end
    parity_mode = 2'b00; stop2 = 1'b0;
  endtask

  task automatic test_fifo_full;
    baud_div = 16'd100;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      bus.tdata  = 8'(i);
      bus.tvalid = 1'b1;
      if (i == 17) begin
        n_cmp++; if (bus.tready !== 1'b0) begin n_fail++; $display("FAIL full_tready got %b want 0", bus.tready); end
        n_cmp++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL full_level got %0d want 16", fifo_level); end
      end else begin
        @(posedge clk);
      end
    end
    repeat (50) @(negedge clk);
    n_cmp++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL full_hold_level got %0d want 16", fifo_level); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy got %b want 1", busy); end
    bus.tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL full_flush got %0d want 0", fifo_level); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midframe;
    int lows, busys;
    baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    push(8'h5A);
    push(8'h33);
    repeat (18) @(negedge clk);
    n_cmp++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL mid_pre_level got %0d want 1", fifo_level); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1)       begin n_fail++; $display("FAIL mid_tx got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL mid_level got %0d want 0", fifo_level); end
    n_cmp++; if (bus.tready !== 1'b1) begin n_fail++; $display("FAIL mid_tready got %b want 1", bus.tready); end
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0; busys = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx !== 1'b1)   lows++;
      if (busy !== 1'b0) busys++;
    end
    n_cmp++; if (lows !== 0)  begin n_fail++; $display("FAIL post_reset_tx_low got %0d cycles want 0", lows); end
    n_cmp++; if (busys !== 0) begin n_fail++; $display("FAIL post_reset_busy got %0d cycles want 0", busys); end
  endtask

  task automatic test_cfg_change;
    logic [31:0] f, l, e1, e2;
    baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    e1 = {22'd0, 1'b1, 8'hA5, 1'b0};
    e2 = {22'd0, 1'b1, 8'h3C, 1'b0};
    push(8'hA5);
    push(8'h3C);
    baud_div = 16'd7;
    capture(10, 4, f, l);
    n_cmp++; if (f !== e1) begin n_fail++; $display("FAIL cfg_f1_first got %b want %b", f, e1); end
    n_cmp++; if (l !== e1) begin n_fail++; $display("FAIL cfg_f1_last got %b want %b", l, e1); end
    capture(10, 8, f, l);
    n_cmp++; if (f !== e2) begin n_fail++; $display("FAIL cfg_f2_first got %b want %b", f, e2); end
    n_cmp++; if (l !== e2) begin n_fail++; $display("FAIL cfg_f2_last got %b want %b", l, e2); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cfg_end_busy got %b want 0", busy); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_div0();
    test_fifo_full();
    test_reset_midframe();
    test_cfg_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
